// File: rtl/hc595_shift_driver_pkg.sv
// Shared definitions for the SN74HC595 serial driver: FSM state encoding
// and the default chain geometry reused by the top level and its bench.
package hc595_shift_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SH_LO = 2'd1,
        SH_HI = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_CLK_DIV = 2;

endpackage

// File: rtl/hc595_shift_driver_if.sv
// Parallel-side handshake between the display producer and the 595 driver.
interface hc595_shift_driver_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH-1:0] din;
    logic             start;
    logic             busy;
    logic             done;
    logic             pending;

    modport master (
        output din,
        output start,
        input  busy,
        input  done,
        input  pending
    );

    modport slave (
        input  din,
        input  start,
        output busy,
        output done,
        output pending
    );

endinterface

// File: rtl/hc595_shift_driver_tick_div.sv
// Phase counter for the shift-clock half period: counts 0..CLK_DIV-1 and
// flags the terminal count; restart holds it at phase 0.
module hc595_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DCW-1:0] div_cnt;

    assign tick = (div_cnt == DCW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (restart || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DCW'(1);
        end
    end

endmodule

// File: rtl/hc595_shift_driver.sv
// Serialises a parallel frame onto an SN74HC595 chain (SER/SRCLK/RCLK) with a
// start/busy/done handshake and a one-deep pending frame buffer.
module hc595_shift_driver
    import hc595_shift_driver_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hc595_shift_driver_if.slave  bus,
    output logic                 SN74HC595_data,
    output logic                 SN74HC595_data_clk,
    output logic                 SN74HC595_refresh_clk
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_sh;
    logic [WIDTH-1:0] pend_buf;
    logic [WIDTH-1:0] next_frame;
    logic [BCW-1:0]   bit_cnt;
    logic             busy_q;
    logic             done_q;
    logic             pending_q;
    logic             ser_q;
    logic             srclk_q;
    logic             rclk_q;
    logic             tick;
    logic             restart;
    logic             complete;

    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    assign restart  = (state == IDLE);
    assign complete = (state == LATCH) && tick;

    hc595_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        shreg_sh = shreg;
        if (MSB_FIRST) begin
            shreg_sh = shreg << 1;
        end else begin
            shreg_sh = shreg >> 1;
        end
    end

    // A start on the completion cycle takes priority over the buffered frame.
    always_comb begin
        next_frame = pend_buf;
        if (bus.start) begin
            next_frame = bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            pend_buf  <= '0;
            bit_cnt   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
            ser_q     <= 1'b0;
            srclk_q   <= 1'b0;
            rclk_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start && busy_q && !complete) begin
                pend_buf  <= bus.din;
                pending_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= SH_LO;
                        shreg   <= bus.din;
                        bit_cnt <= BCW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        ser_q   <= lead_bit(bus.din);
                        srclk_q <= 1'b0;
                        rclk_q  <= 1'b0;
                    end
                end
                SH_LO: begin
                    if (tick) begin
                        state   <= SH_HI;
                        srclk_q <= 1'b1;
                    end
                end
                SH_HI: begin
                    if (tick) begin
                        shreg   <= shreg_sh;
                        srclk_q <= 1'b0;
                        if (bit_cnt == '0) begin
                            state  <= LATCH;
                            rclk_q <= 1'b1;
                            ser_q  <= 1'b0;
                        end else begin
                            state   <= SH_LO;
                            bit_cnt <= bit_cnt - BCW'(1);
                            ser_q   <= lead_bit(shreg_sh);
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        done_q <= 1'b1;
                        rclk_q <= 1'b0;
                        if (bus.start || pending_q) begin
                            state     <= SH_LO;
                            shreg     <= next_frame;
                            bit_cnt   <= BCW'(WIDTH - 1);
                            ser_q     <= lead_bit(next_frame);
                            pending_q <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.pending           = pending_q;
    assign SN74HC595_data        = ser_q;
    assign SN74HC595_data_clk    = srclk_q;
    assign SN74HC595_refresh_clk = rclk_q;

endmodule

// File: tb/tb_hc595_shift_driver.sv
// Scoreboard bench for hc595_shift_driver: default 16-bit MSB-first instance
// plus an 8-bit, CLK_DIV=1, LSB-first instance.
module tb_hc595_shift_driver;
    import hc595_shift_driver_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hc595_shift_driver_if #(.WIDTH(DEF_WIDTH)) bus_a ();
    hc595_shift_driver_if #(.WIDTH(8))         bus_b ();

    logic ser_a, sck_a, rck_a;
    logic ser_b, sck_b, rck_b;

    hc595_shift_driver #(
        .WIDTH     (DEF_WIDTH),
        .CLK_DIV   (DEF_CLK_DIV),
        .MSB_FIRST (1'b1)
    ) u_dut_a (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .bus                   (bus_a),
        .SN74HC595_data        (ser_a),
        .SN74HC595_data_clk    (sck_a),
        .SN74HC595_refresh_clk (rck_a)
    );

    hc595_shift_driver #(
        .WIDTH     (8),
        .CLK_DIV   (1),
        .MSB_FIRST (1'b0)
    ) u_dut_b (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .bus                   (bus_b),
        .SN74HC595_data        (ser_b),
        .SN74HC595_data_clk    (sck_b),
        .SN74HC595_refresh_clk (rck_b)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] q_a[$];
    logic [7:0]  q_b[$];
    int          done_at[$];

    int rck_rises_a = 0;
    int done_cnt_a  = 0;
    int sck_rises_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor A: assemble SER at SRCLK rises, score the frame at RCLK rise.
    logic        prev_sck_a = 1'b0;
    logic        prev_rck_a = 1'b0;
    logic [15:0] bits_a = '0;
    int          nbits_a = 0;
    int          rhi_a = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits_a = 0;
            bits_a  = '0;
            rhi_a   = 0;
        end else begin
            if (sck_a && !prev_sck_a) begin
                bits_a = {bits_a[14:0], ser_a};
                nbits_a++;
            end
            if (rck_a && !prev_rck_a) begin
                rck_rises_a++;
                check("a_bitcount", nbits_a, 16);
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_frame: got=%0h want=<none queued>", bits_a);
                end else begin
                    check("a_frame", bits_a, q_a.pop_front());
                end
                nbits_a = 0;
            end
            if (rck_a) begin
                rhi_a++;
            end else if (prev_rck_a) begin
                check("a_rclk_width", rhi_a, 2);
                rhi_a = 0;
            end
            if (bus_a.done) done_cnt_a++;
        end
        prev_sck_a = sck_a;
        prev_rck_a = rck_a;
    end

    // Monitor B: LSB-first, so each new bit enters at the top.
    logic       prev_sck_b = 1'b0;
    logic       prev_rck_b = 1'b0;
    logic [7:0] bits_b = '0;
    int         nbits_b = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits_b = 0;
            bits_b  = '0;
        end else begin
            if (sck_b && !prev_sck_b) begin
                bits_b = {ser_b, bits_b[7:1]};
                nbits_b++;
                sck_rises_b++;
            end
            if (rck_b && !prev_rck_b) begin
                check("b_bitcount", nbits_b, 8);
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_frame: got=%0h want=<none queued>", bits_b);
                end else begin
                    check("b_frame", bits_b, q_b.pop_front());
                end
                nbits_b = 0;
            end
        end
        prev_sck_b = sck_b;
        prev_rck_b = rck_b;
    end

    // Start must already be presented before the call; iteration n drives
    // inputs just after rising edge n and samples cycle n on the falling edge.
    task automatic run_a(input int tid, input int limit, output int bc, output int dn,
                         output logic saw_pend, output logic done_at_end);
        logic last_done;
        bc = 0;
        dn = 0;
        saw_pend = 1'b0;
        done_at_end = 1'b0;
        last_done = 1'b0;
        done_at.delete();
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            case (tid)
                2: begin
                    bus_a.start = (n == 10) || (n == 20);
                    if (n == 10) bus_a.din = 16'h00FF;
                    if (n == 20) bus_a.din = 16'h0F0F;
                end
                3: begin
                    if (n == 1) bus_a.din = 16'h0000;
                    if (last_done) bus_a.din = ~bus_a.din;
                    if (n == 133) bus_a.start = 1'b0;
                end
                6: begin
                    bus_a.start = (n == 66);
                    if (n == 66) bus_a.din = 16'hC0DE;
                end
                default: bus_a.start = 1'b0;
            endcase
            @(negedge clk);
            last_done = bus_a.done;
            if (bus_a.done) begin
                dn++;
                done_at.push_back(n);
            end
            if (bus_a.pending) saw_pend = 1'b1;
            if (tid == 2 && (n == 11 || n == 21)) check("t2_pending_set", bus_a.pending, 1);
            if (tid == 2 && n == 67) check("t2_pending_clear", bus_a.pending, 0);
            if (!bus_a.busy) begin
                done_at_end = bus_a.done;
                break;
            end
            bc++;
        end
    endtask

    int   bc, dn, r0, s0;
    logic sp, de, toggle_ok;

    initial begin
        bus_a.start = 1'b0;
        bus_a.din   = '0;
        bus_b.start = 1'b0;
        bus_b.din   = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus_a.busy, 0);
        check("rst_done", bus_a.done, 0);
        check("rst_pending", bus_a.pending, 0);
        check("rst_ser", ser_a, 0);
        check("rst_srclk", sck_a, 0);
        check("rst_rclk", rck_a, 0);
        check("rst_busy_b", bus_b.busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single frame
        @(posedge clk);
        #1;
        bus_a.din = 16'hA5C3;
        bus_a.start = 1'b1;
        q_a.push_back(16'hA5C3);
        run_a(1, 300, bc, dn, sp, de);
        check("t1_busy_cycles", bc, 66);
        check("t1_done_pulses", dn, 1);
        check("t1_done_with_busy_fall", de, 1);

        // 2: pending overwritten, back-to-back
        @(posedge clk);
        #1;
        bus_a.din = 16'h3C96;
        bus_a.start = 1'b1;
        q_a.push_back(16'h3C96);
        q_a.push_back(16'h0F0F);
        run_a(2, 400, bc, dn, sp, de);
        check("t2_busy_cycles", bc, 132);
        check("t2_done_pulses", dn, 2);
        check("t2_done1_cycle", done_at[0], 67);

        // 3: start held, alternating frames
        @(posedge clk);
        #1;
        bus_a.din = 16'hFFFF;
        bus_a.start = 1'b1;
        q_a.push_back(16'hFFFF);
        q_a.push_back(16'h0000);
        q_a.push_back(16'hFFFF);
        run_a(3, 500, bc, dn, sp, de);
        check("t3_busy_cycles", bc, 198);
        check("t3_done_pulses", dn, 3);
        check("t3_done1_cycle", done_at[0], 67);
        check("t3_done2_cycle", done_at[1], 133);
        check("t3_done3_cycle", done_at[2], 199);

        // 4: reset mid-frame with a frame pending
        r0 = rck_rises_a;
        @(posedge clk);
        #1;
        bus_a.din = 16'h1234;
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        bus_a.din = 16'hBEEF;
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t4_busy_async", bus_a.busy, 0);
        check("t4_pending_async", bus_a.pending, 0);
        check("t4_ser_async", ser_a, 0);
        check("t4_srclk_async", sck_a, 0);
        check("t4_rclk_async", rck_a, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        check("t4_no_rclk", rck_rises_a, r0);
        @(posedge clk);
        #1;
        bus_a.din = 16'h5A5A;
        bus_a.start = 1'b1;
        q_a.push_back(16'h5A5A);
        run_a(1, 300, bc, dn, sp, de);
        check("t4_busy_cycles", bc, 66);
        check("t4_done_pulses", dn, 1);

        // 6: start exactly on the completion cycle
        @(posedge clk);
        #1;
        bus_a.din = 16'h9669;
        bus_a.start = 1'b1;
        q_a.push_back(16'h9669);
        q_a.push_back(16'hC0DE);
        run_a(6, 400, bc, dn, sp, de);
        check("t6_busy_cycles", bc, 132);
        check("t6_done_pulses", dn, 2);
        check("t6_never_pending", sp, 0);

        // 5: 8-bit, CLK_DIV=1, LSB first
        s0 = sck_rises_b;
        toggle_ok = 1'b1;
        bc = 0;
        @(posedge clk);
        #1;
        bus_b.din = 8'h01;
        bus_b.start = 1'b1;
        q_b.push_back(8'h01);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1 bus_b.start = 1'b0;
            @(negedge clk);
            if (!bus_b.busy) break;
            if (n <= 16 && sck_b !== ((n % 2) == 0)) toggle_ok = 1'b0;
            bc++;
        end
        check("t5_busy_cycles", bc, 17);
        check("t5_srclk_toggle", toggle_ok, 1);
        check("t5_srclk_rises", sck_rises_b - s0, 8);

        repeat (5) @(posedge clk);
        check("sb_a_drained", q_a.size(), 0);
        check("sb_b_drained", q_b.size(), 0);
        check("a_total_done", done_cnt_a, 9);
        check("a_total_rclk", rck_rises_a, 9);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hc595_shift_driver.md
Name: hc595_shift_driver

Overview:
Serialises a parallel word onto the SN74HC595 chain: serial data, shift clock, and storage/refresh clock. Sits directly downstream of the traffic-light control/display logic inside top. It drives the top-level pins SN74HC595_data, SN74HC595_data_clk and SN74HC595_refresh_clk. Parallel side uses a start/busy/done handshake with a one-deep pending buffer, so the producer can post updates at any time without stalling.

Parameters:
WIDTH, 16, bits per frame (total 595 chain length); legal range >= 1
CLK_DIV, 2, clk cycles per half period of the shift clock; legal range >= 1
MSB_FIRST, 1, 1 = din[WIDTH-1] shifted first; 0 = din[0] shifted first

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
din  in  WIDTH  parallel frame; sampled only when start is accepted
start  in  1  request a transfer of din; level-sampled every cycle
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when a frame has been latched to the 595 outputs
pending  out  1  a frame is buffered and waiting behind the current transfer
SN74HC595_data  out  1  serial data (SER)
SN74HC595_data_clk  out  1  shift clock (SRCLK); 595 samples SER on its rising edge
SN74HC595_refresh_clk  out  1  storage clock (RCLK); rising edge copies shift reg to outputs

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low. While reset is asserted, all outputs are 0, the FSM is in IDLE, and the pending buffer is empty.
- FSM states: IDLE, SH_LO, SH_HI, LATCH. A divider counter div_cnt runs 0..CLK_DIV-1; each state lasts exactly CLK_DIV cycles.
- IDLE, start=1: capture din into the shift register, set bit_cnt=WIDTH-1, go to SH_LO. busy rises on the next cycle.
- SH_LO: SRCLK=0, RCLK=0, SER=current bit (shreg MSB if MSB_FIRST, else LSB), driven from state entry.
- SH_HI: SRCLK=1, SER held.
  - At the end of SH_HI, shift the register by one.
  - If bit_cnt==0, go to LATCH; otherwise decrement bit_cnt and go to SH_LO.
  - SER changes only on SH_LO entry, so setup and hold are each >= CLK_DIV cycles around the SRCLK rise.
- LATCH: RCLK=1, SRCLK=0, SER=0.
- End of LATCH is the completion cycle:
  - done=1 for one cycle.
  - If a frame is pending, or start=1 in this cycle: load that frame and go to SH_LO; busy stays 1 and pending clears. If both are present, start's din wins.
  - Otherwise go to IDLE; busy=0 and done=1 in the same cycle.
- Frame busy time: (2*WIDTH+1)*CLK_DIV cycles. Defaults give 66 cycles, with exactly 16 SRCLK rises and 1 RCLK pulse.
- start=1 while busy (other than the completion cycle): store din in the pending buffer and set pending=1. A later start overwrites the buffer (latest wins). Only one frame is ever queued.
- start held high continuously: back-to-back frames with no IDLE gap; din is resampled at each completion cycle.
- Reset mid-frame: abort immediately; pins go 0 and no RCLK pulse is produced, so the 595 outputs keep their previous frame. The pending buffer is lost.
- Counter widths: bit_cnt uses $clog2(WIDTH) (min 1); div_cnt uses $clog2(CLK_DIV) (min 1). No wrap beyond the terminal value.

Decomposition:
- Shared header/package hc595_defs: state encodings (IDLE=2'd0, SH_LO=2'd1, SH_HI=2'd2, LATCH=2'd3) and default WIDTH/CLK_DIV constants. top and the bench reuse these for the chain length.
- One natural sub-module: hc595_tick_div, a CLK_DIV phase counter with a restart input and a one-cycle terminal tick output.
- FSM and datapath stay in hc595_shift_driver.

Test Plan:
1. Defaults, one start pulse with din=16'hA5C3 -> SER sampled at 16 SRCLK rises reads 1010010111000011; busy high for 66 cycles; one RCLK pulse of 2 cycles; done pulses once as busy falls.
2. Second start (din=16'h00FF) at cycle 10 of frame 1, third start (16'h0F0F) at cycle 20 -> pending=1 from cycle 11; 16'h00FF is dropped; frame 2 shifts 16'h0F0F with no IDLE gap; exactly two done pulses.
3. start held high with din toggling between 16'hFFFF and 16'h0000 at each done -> frames alternate all-ones/all-zeros; busy stays 1 continuously; done every 66 cycles.
4. rst_n pulled low at cycle 30 of a frame, released 5 cycles later -> all pins and busy 0 asynchronously; no RCLK rise; next start transfers normally.
5. WIDTH=8, CLK_DIV=1, MSB_FIRST=0, din=8'h01 -> first SER bit 1 then seven 0s; busy 17 cycles; SRCLK toggles every cycle.
6. start asserted exactly on the completion cycle with nothing pending -> new frame begins next cycle; busy never drops; pending stays 0.
